// File: rtl/operand_fetch.sv
// operand_fetch
//   Read-side companion to the 4 x 8-bit signed register file. Takes one
//   decoded instruction at a time and holds it until neither source
//   register nor (if it writes) the destination register has a write
//   pending. It then reads both operands, taking the writeback value
//   directly when that register is being written in the same cycle, and
//   presents them to execute over a valid/ready handshake.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     decode handshake (in_ready high only in IDLE)
//   in_ra, in_rb, in_wb   source / destination register addresses
//   in_writes             instruction will write in_wb
//   rf_ra, rf_rb          register file read addresses (latched ra/rb)
//   rf_data1, rf_data2    register file read data
//   wb_valid, wb_addr,
//   wb_data               writeback port, same strobe as the register file write
//   out_valid/out_ready   execute handshake
//   out_a, out_b          captured operands
//   out_wb, out_writes    destination carried along with the operands
//   sb_busy               bit n = write pending to register n
//   sb_err                sticky: writeback to a register that was not pending

module operand_fetch (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_ra,
  input  logic [1:0]        in_rb,
  input  logic [1:0]        in_wb,
  input  logic              in_writes,
  output logic [1:0]        rf_ra,
  output logic [1:0]        rf_rb,
  input  logic signed [7:0] rf_data1,
  input  logic signed [7:0] rf_data2,
  input  logic              wb_valid,
  input  logic [1:0]        wb_addr,
  input  logic signed [7:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] out_a,
  output logic signed [7:0] out_b,
  output logic [1:0]        out_wb,
  output logic              out_writes,
  output logic [3:0]        sb_busy,
  output logic              sb_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [1:0]        ra_reg, rb_reg, wb_reg;
  logic              writes_reg;
  logic signed [7:0] a_reg, b_reg;
  logic [1:0]        out_wb_reg;
  logic              out_writes_reg;
  logic [3:0]        sb_busy_reg, sb_busy_next;
  logic              sb_err_reg;

  logic [3:0]        eff_busy;
  logic [3:0]        wb_hit;
  logic              hazard;
  logic              capture;
  logic              accept;
  logic signed [7:0] a_next, b_next;

  // A register being written back this cycle is no longer a hazard: its
  // value is available on wb_data and is bypassed into the capture.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_busy
      assign wb_hit[gi]   = wb_valid && (wb_addr == 2'(gi));
      assign eff_busy[gi] = sb_busy_reg[gi] && !wb_hit[gi];
    end
  endgenerate

  assign hazard  = eff_busy[ra_reg] || eff_busy[rb_reg] ||
                   (writes_reg && eff_busy[wb_reg]);
  assign accept  = (state_reg == IDLE) && in_valid;
  assign capture = (state_reg == FETCH) && !hazard;

  assign a_next = wb_hit[ra_reg] ? wb_data : rf_data1;
  assign b_next = wb_hit[rb_reg] ? wb_data : rf_data2;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = FETCH;
      FETCH:   if (!hazard)   state_next = ISSUE;
      ISSUE:   if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Clear from writeback first, then set from capture, so a register that
  // retires and is re-claimed in the same cycle stays pending.
  always_comb begin
    sb_busy_next = sb_busy_reg;
    if (wb_valid)
      sb_busy_next[wb_addr] = 1'b0;
    if (capture && writes_reg)
      sb_busy_next[wb_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ra_reg         <= 2'd0;
      rb_reg         <= 2'd0;
      wb_reg         <= 2'd0;
      writes_reg     <= 1'b0;
      a_reg          <= 8'sd0;
      b_reg          <= 8'sd0;
      out_wb_reg     <= 2'd0;
      out_writes_reg <= 1'b0;
      sb_busy_reg    <= 4'b0000;
      sb_err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sb_busy_reg <= sb_busy_next;
      if (wb_valid && !sb_busy_reg[wb_addr])
        sb_err_reg <= 1'b1;
      if (accept) begin
        ra_reg     <= in_ra;
        rb_reg     <= in_rb;
        wb_reg     <= in_wb;
        writes_reg <= in_writes;
      end
      if (capture) begin
        a_reg          <= a_next;
        b_reg          <= b_next;
        out_wb_reg     <= wb_reg;
        out_writes_reg <= writes_reg;
      end
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == ISSUE);
  assign rf_ra      = ra_reg;
  assign rf_rb      = rb_reg;
  assign out_a      = a_reg;
  assign out_b      = b_reg;
  assign out_wb     = out_wb_reg;
  assign out_writes = out_writes_reg;
  assign sb_busy    = sb_busy_reg;
  assign sb_err     = sb_err_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
//   Self-checking bench for operand_fetch. A small register file array owned
//   by the bench drives rf_data1/rf_data2; it is only changed explicitly by
//   the tests, so bypassed writeback values are distinguishable from stale
//   register file contents. Expected operand bundles are queued when an
//   instruction is driven and compared when the block presents it.

module tb_operand_fetch;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_ra = 2'd0, in_rb = 2'd0, in_wb = 2'd0;
  logic              in_writes = 1'b0;
  logic [1:0]        rf_ra, rf_rb;
  logic signed [7:0] rf_data1, rf_data2;
  logic              wb_valid = 1'b0;
  logic [1:0]        wb_addr = 2'd0;
  logic signed [7:0] wb_data = 8'sd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [7:0] out_a, out_b;
  logic [1:0]        out_wb;
  logic              out_writes;
  logic [3:0]        sb_busy;
  logic              sb_err;

  logic signed [7:0] rf_mem [4];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] wb;
    logic       w;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign rf_data1 = rf_mem[rf_ra];
  assign rf_data2 = rf_mem[rf_rb];

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra(in_ra), .in_rb(in_rb), .in_wb(in_wb), .in_writes(in_writes),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_wb(out_wb), .out_writes(out_writes),
    .sb_busy(sb_busy), .sb_err(sb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in IDLE and queue its expected operands.
  task automatic accept(input logic [1:0] ra, input logic [1:0] rb,
                        input logic [1:0] wb, input logic w,
                        input logic [7:0] ea, input logic [7:0] eb);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: in_ready=%b required 1 within 20 cycles", in_ready);
    end
    in_ra = ra; in_rb = rb; in_wb = wb; in_writes = w; in_valid = 1'b1;
    exp_q.push_back('{a: ea, b: eb, wb: wb, w: w});
    $display("accept ra=%0d rb=%0d wb=%0d writes=%0b exp_a=%0d exp_b=%0d",
             ra, rb, wb, w, $signed(ea), $signed(eb));
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; lat counts cycles after the accept edge.
  task automatic wait_issue(input int max, output int lat);
    lat = 0;
    while (!out_valid && lat < max) begin
      tick();
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL issue_timeout: out_valid=%b required 1 within %0d cycles", out_valid, max);
    end
  endtask

  task automatic writeback(input logic [1:0] addr, input logic signed [7:0] data);
    wb_valid = 1'b1; wb_addr = addr; wb_data = data;
    $display("writeback addr=%0d data=%0d", addr, data);
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_a, out_b, out_wb, out_writes, sb_busy, sb_err} !==
        {1'b1, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b a=%h b=%h wb=%0d w=%b sb=%b err=%b required 1 0 00 00 0 0 0000 0",
               in_ready, out_valid, out_a, out_b, out_wb, out_writes, sb_busy, sb_err);
    end
    $display("reset done");
  endtask

  task automatic test_no_hazard();
    int lat;
    rf_mem[1] = 8'sd5;
    rf_mem[2] = -8'sd3;
    accept(2'd1, 2'd2, 2'd3, 1'b1, 8'd5, 8'hFD);
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL nohaz_fetch: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    wait_issue(10, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL nohaz_latency: %0d cycles after accept edge required 1", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if ({out_a, out_b, out_wb, out_writes} !== e) begin
      errors++;
      $display("FAIL nohaz_data: a=%h b=%h wb=%0d w=%b required %h %h %0d %b",
               out_a, out_b, out_wb, out_writes, e.a, e.b, e.wb, e.w);
    end
    checks++;
    if (sb_busy !== 4'b1000) begin
      errors++;
      $display("FAIL nohaz_sb: sb_busy=%b required 1000", sb_busy);
    end
    tick();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL nohaz_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  // R3 is pending from the previous test; the stale register file holds 7.
  task automatic test_raw();
    rf_mem[3] = 8'sd7;
    rf_mem[0] = 8'sd11;
    accept(2'd3, 2'd0, 2'd0, 1'b0, 8'd42, 8'd11);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
        errors++;
        $display("FAIL raw_stall cycle %0d: out_valid=%b in_ready=%b required 0 0", i, out_valid, in_ready);
      end
      tick();
    end
    writeback(2'd3, 8'sd42);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL raw_issue: out_valid=%b required 1", out_valid);
    end
    e = exp_q.pop_front();
    checks++;
    if ({out_a, out_b, out_wb, out_writes} !== e) begin
      errors++;
      $display("FAIL raw_bypass: a=%0d b=%0d wb=%0d w=%b required %0d %0d %0d %b",
               out_a, out_b, out_wb, out_writes, $signed(e.a), $signed(e.b), e.wb, e.w);
    end
    checks++;
    if (sb_busy !== 4'b0000) begin
      errors++;
      $display("FAIL raw_sb: sb_busy=%b required 0000", sb_busy);
    end
    rf_mem[3] = 8'sd42;
    tick();
  endtask

  task automatic test_waw();
    int lat;
    accept(2'd0, 2'd0, 2'd2, 1'b1, 8'd11, 8'd11);
    wait_issue(10, lat);
    e = exp_q.pop_front();
    checks++;
    if ({out_a, out_b, out_wb, out_writes} !== e) begin
      errors++;
      $display("FAIL waw_first: a=%0d b=%0d wb=%0d w=%b required %0d %0d %0d %b",
               out_a, out_b, out_wb, out_writes, $signed(e.a), $signed(e.b), e.wb, e.w);
    end
    tick();
    accept(2'd0, 2'd1, 2'd2, 1'b1, 8'd11, 8'd5);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL waw_stall cycle %0d: out_valid=%b required 0", i, out_valid);
      end
      tick();
    end
    writeback(2'd2, 8'sd9);
    checks++;
    if ({out_valid, sb_busy, sb_err} !== {1'b1, 4'b0100, 1'b0}) begin
      errors++;
      $display("FAIL waw_setwins: out_valid=%b sb_busy=%b sb_err=%b required 1 0100 0", out_valid, sb_busy, sb_err);
    end
    e = exp_q.pop_front();
    checks++;
    if ({out_a, out_b, out_wb, out_writes} !== e) begin
      errors++;
      $display("FAIL waw_data: a=%0d b=%0d wb=%0d w=%b required %0d %0d %0d %b",
               out_a, out_b, out_wb, out_writes, $signed(e.a), $signed(e.b), e.wb, e.w);
    end
    tick();
    writeback(2'd2, 8'sd9);
    checks++;
    if ({sb_busy, sb_err} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL waw_retire: sb_busy=%b sb_err=%b required 0000 0", sb_busy, sb_err);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    accept(2'd1, 2'd2, 2'd1, 1'b1, 8'd5, 8'hFD);
    wait_issue(10, lat);
    e = exp_q[0];
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({out_valid, in_ready, out_a, out_b, out_wb, out_writes} !== {2'b10, e}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: v=%b rdy=%b a=%h b=%h wb=%0d w=%b required 1 0 %h %h %0d %b",
                 i, out_valid, in_ready, out_a, out_b, out_wb, out_writes, e.a, e.b, e.wb, e.w);
      end
      tick();
    end
    out_ready = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if ({out_a, out_b, out_wb, out_writes} !== e) begin
      errors++;
      $display("FAIL bp_data: a=%h b=%h wb=%0d w=%b required %h %h %0d %b",
               out_a, out_b, out_wb, out_writes, e.a, e.b, e.wb, e.w);
    end
    tick();
    checks++;
    if ({in_ready, out_valid, sb_busy} !== {2'b10, 4'b0010}) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b sb_busy=%b required 1 0 0010", in_ready, out_valid, sb_busy);
    end
    writeback(2'd1, 8'sd1);
  endtask

  task automatic test_spurious();
    checks++;
    if ({sb_busy, sb_err} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL spur_pre: sb_busy=%b sb_err=%b required 0000 0", sb_busy, sb_err);
    end
    writeback(2'd1, 8'sd3);
    checks++;
    if ({sb_busy, sb_err} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL spur_err: sb_busy=%b sb_err=%b required 0000 1", sb_busy, sb_err);
    end
    tick(); tick(); tick();
    checks++;
    if (sb_err !== 1'b1) begin
      errors++;
      $display("FAIL spur_sticky: sb_err=%b required 1", sb_err);
    end
  endtask

  task automatic test_reset_mid_issue();
    int lat;
    out_ready = 1'b0;
    accept(2'd0, 2'd1, 2'd3, 1'b1, 8'd11, 8'd5);
    wait_issue(10, lat);
    checks++;
    if (sb_busy !== 4'b1000) begin
      errors++;
      $display("FAIL rst_pre: sb_busy=%b required 1000", sb_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if ({out_valid, in_ready, sb_busy, out_a, out_b, sb_err} !==
        {1'b0, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_issue: v=%b rdy=%b sb=%b a=%h b=%h err=%b required 0 1 0000 00 00 0",
               out_valid, in_ready, sb_busy, out_a, out_b, sb_err);
    end
    out_ready = 1'b1;
    $display("reset mid-issue done");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf_mem[i] = 8'sd0;
    test_reset();
    test_no_hazard();
    test_raw();
    test_waw();
    test_backpressure();
    test_spurious();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Read-side companion to the 4 x 8-bit signed register file. Accepts a decoded instruction (ra, rb, wb), stalls while a source or destination register has a write outstanding (scoreboard), reads both operands from the register file with writeback bypass, and hands them to the ALU stage over a valid/ready handshake. Sits between decode and execute; the writeback port mirrors the register file write port.

## Interface
- No parameters; widths fixed: 2-bit register address, 8-bit signed data, 4 registers.
- clk  in  1  rising-edge clock. Register file writes on falling edge; this block is entirely rising-edge.
- rst  in  1  reset rst, synchronous, active-high.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  block can accept; high only in IDLE.
- in_ra, in_rb  in  2 each  source register addresses.
- in_wb  in  2  destination register address.
- in_writes  in  1  instruction will write in_wb.
- rf_ra, rf_rb  out  2 each  register file read addresses; combinational from latched ra/rb.
- rf_data1, rf_data2  in  8 signed each  register file read data.
- wb_valid  in  1  writeback this cycle (same strobe that writes the register file).
- wb_addr  in  2  writeback register.
- wb_data  in  8 signed  writeback value.
- out_valid  out  1  operands valid to execute.
- out_ready  in  1  execute accepts.
- out_a, out_b  out  8 signed each  operand values (registered).
- out_wb  out  2, out_writes  out  1  destination carried with operands (registered).
- sb_busy  out  4  scoreboard, bit n = write pending to register n.
- sb_err  out  1  sticky: writeback seen to a register not marked busy.

## Operation
- States: IDLE, FETCH, ISSUE.
- IDLE: in_ready=1. On in_valid: latch ra, rb, wb, writes; go FETCH.
- FETCH: per register n, eff_busy[n] = sb_busy[n] and not (wb_valid and wb_addr==n). hazard = eff_busy[ra] or eff_busy[rb] or (writes and eff_busy[wb]). hazard: stay FETCH. No hazard: capture operands, set sb_busy[wb] if writes, go ISSUE.
- Operand capture with bypass: out_a = wb_data if wb_valid and wb_addr==ra, else rf_data1; likewise out_b with rb / rf_data2. ra==rb legal; both get the same value.
- ISSUE: out_valid=1; out_* held stable. On out_ready: go IDLE.
- Scoreboard update each edge: clear sb_busy[wb_addr] on wb_valid; set from FETCH capture applied after, so set wins when same register is cleared and set in one cycle (resulting bit = 1).
- wb_valid with sb_busy[wb_addr]=0: scoreboard unchanged, sb_err set, held until rst.
- wb_valid processed in every state, including IDLE and ISSUE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_a=out_b=0, out_wb=0, out_writes=0, sb_busy=0000, sb_err=0. rst in any state drops the held instruction and all pending scoreboard bits.
- Accept at edge E0 -> FETCH during cycle 1 -> no hazard: out_valid=1 after E1 (2-cycle latency). Each hazard cycle adds one.
- Hazard cleared by wb_valid in the same FETCH cycle: no extra stall; bypassed value captured at that edge.
- out_valid&&out_ready at edge Ek -> in_ready=1 in cycle k+1; peak throughput 1 instruction per 3 cycles.
- rf_ra/rf_rb valid the whole FETCH cycle; register file output assumed settled before the rising edge.
- sb_busy set visible the cycle after capture, before out_valid could be consumed.

## Test plan
- Reset: drive rst=1 mid-ISSUE -> next cycle out_valid=0, sb_busy=0000, in_ready=1, out_a=out_b=0.
- No hazard: R1=5, R2=-3 preloaded, accept ra=1 rb=2 wb=3 writes=1, out_ready=1 -> out_valid 2 cycles after accept, out_a=5, out_b=-3 (8'hFD), out_wb=3, sb_busy=1000.
- RAW stall: R3 busy, accept ra=3 rb=0 -> stays FETCH 4 cycles; wb_valid wb_addr=3 wb_data=42 in 5th cycle -> out_a=42 captured that edge, sb_busy[3]=0.
- WAW: R2 busy, accept wb=2 writes=1 ra=0 rb=1 -> stall until wb_addr=2 writeback; same edge sb_busy[2] stays 1 (set wins).
- Backpressure: out_ready=0 for 6 cycles in ISSUE -> out_a/out_b/out_wb unchanged, in_ready=0 throughout; accept on out_ready=1.
- Spurious writeback: wb_valid wb_addr=1 with sb_busy=0000 -> sb_err=1 next cycle, stays 1 until rst.
